piece_move_commit: RTL and testbench

- Consumer side of the move-proposal path: takes the candidate position/rotation proposed for the active piece, runs it through the board collision checker, then commits it or rejects it.
- Owns the active piece's registered cur_pos_x/cur_pos_y/cur_rot, which feed back to the proposal calculator.
- A blocked downward move locks the piece into the board, then respawns.
- Detects game over when a freshly spawned piece collides.

---
 rtl/piece_move_commit.sv | 179 +++++++++++++++++
 tb/tb_piece_move_commit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/piece_move_commit.sv
// piece_move_commit: commits or rejects move proposals for the active piece.
// Each proposal is latched and sent to the board collision checker. A clear
// result commits it; a blocked downward move locks the piece and respawns.
// Gravity ticks that arrive while busy are remembered and replayed once.
module piece_move_commit #(
  parameter logic [2:0] PLAY_MODE = 3'd1,
  parameter logic [3:0] SPAWN_X   = 4'd4,
  parameter logic [4:0] SPAWN_Y   = 5'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] mode,
  input  logic       game_tick,
  input  logic       btn_left_en,
  input  logic       btn_right_en,
  input  logic       btn_rotate_en,
  input  logic       btn_down_en,
  input  logic [3:0] test_pos_x,
  input  logic [4:0] test_pos_y,
  input  logic [1:0] test_rot,
  input  logic       check_done,
  input  logic       check_collides,
  input  logic       lock_done,
  output logic [3:0] cur_pos_x,
  output logic [4:0] cur_pos_y,
  output logic [1:0] cur_rot,
  output logic [3:0] chk_pos_x,
  output logic [4:0] chk_pos_y,
  output logic [1:0] chk_rot,
  output logic       check_req,
  output logic       lock_req,
  output logic       spawn_pulse,
  output logic       game_over,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_SPAWN_CHK, S_PLAY, S_CHECK, S_LOCK, S_OVER
  } state_t;

  state_t state;
  logic   tick_pending;
  logic   is_down;

  logic mode_live;
  logic any_event;
  logic event_down;

  // A gravity tick outranks every button; down only wins when no sideways or
  // rotate button is pressed in the same cycle.
  assign mode_live  = (mode == PLAY_MODE);
  assign any_event  = game_tick | btn_left_en | btn_right_en | btn_rotate_en | btn_down_en;
  assign event_down = game_tick |
                      (btn_down_en & ~btn_left_en & ~btn_right_en & ~btn_rotate_en);

  // Piece FSM: all outputs and piece state are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cur_pos_x    <= SPAWN_X;
      cur_pos_y    <= SPAWN_Y;
      cur_rot      <= 2'd0;
      chk_pos_x    <= 4'd0;
      chk_pos_y    <= 5'd0;
      chk_rot      <= 2'd0;
      check_req    <= 1'b0;
      lock_req     <= 1'b0;
      spawn_pulse  <= 1'b0;
      game_over    <= 1'b0;
      busy         <= 1'b0;
      tick_pending <= 1'b0;
      is_down      <= 1'b0;
    end else begin
      check_req   <= 1'b0;
      lock_req    <= 1'b0;
      spawn_pulse <= 1'b0;
      if ((state != S_OVER) && !mode_live) begin
        // Leaving play mode abandons any request in flight; the piece holds.
        state        <= S_IDLE;
        busy         <= 1'b0;
        tick_pending <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state        <= S_SPAWN;
            busy         <= 1'b1;
            tick_pending <= 1'b0;
          end
          S_SPAWN: begin
            cur_pos_x    <= SPAWN_X;
            cur_pos_y    <= SPAWN_Y;
            cur_rot      <= 2'd0;
            chk_pos_x    <= SPAWN_X;
            chk_pos_y    <= SPAWN_Y;
            chk_rot      <= 2'd0;
            spawn_pulse  <= 1'b1;
            check_req    <= 1'b1;
            tick_pending <= tick_pending | game_tick;
            state        <= S_SPAWN_CHK;
          end
          S_SPAWN_CHK: begin
            tick_pending <= tick_pending | game_tick;
            if (check_done) begin
              if (check_collides) begin
                state     <= S_OVER;
                game_over <= 1'b1;
              end else begin
                state <= S_PLAY;
                busy  <= 1'b0;
              end
            end
          end
          S_PLAY: begin
            if (tick_pending) begin
              // Replay the deferred tick from the committed position.
              chk_pos_x    <= cur_pos_x;
              chk_pos_y    <= cur_pos_y + 5'd1;
              chk_rot      <= cur_rot;
              tick_pending <= 1'b0;
              is_down      <= 1'b1;
              check_req    <= 1'b1;
              busy         <= 1'b1;
              state        <= S_CHECK;
            end else if (any_event) begin
              chk_pos_x <= test_pos_x;
              chk_pos_y <= test_pos_y;
              chk_rot   <= test_rot;
              is_down   <= event_down;
              check_req <= 1'b1;
              busy      <= 1'b1;
              state     <= S_CHECK;
            end
          end
          S_CHECK: begin
            tick_pending <= tick_pending | game_tick;
            if (check_done) begin
              if (!check_collides) begin
                cur_pos_x <= chk_pos_x;
                cur_pos_y <= chk_pos_y;
                cur_rot   <= chk_rot;
                busy      <= 1'b0;
                state     <= S_PLAY;
              end else if (is_down) begin
                lock_req <= 1'b1;
                state    <= S_LOCK;
              end else begin
                busy  <= 1'b0;
                state <= S_PLAY;
              end
            end
          end
          S_LOCK: begin
            if (lock_done) begin
              // A new piece never inherits a stale drop.
              tick_pending <= 1'b0;
              state        <= S_SPAWN;
            end else begin
              tick_pending <= tick_pending | game_tick;
            end
          end
          S_OVER: begin
            if (mode_live) begin
              game_over <= 1'b1;
            end else begin
              game_over <= 1'b0;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piece_move_commit.sv
// Directed, table-driven bench for piece_move_commit.
module tb_piece_move_commit;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] mode;
  logic       game_tick, btn_left_en, btn_right_en, btn_rotate_en, btn_down_en;
  logic [3:0] test_pos_x;
  logic [4:0] test_pos_y;
  logic [1:0] test_rot;
  logic       check_done, check_collides, lock_done;
  logic [3:0] cur_pos_x, chk_pos_x;
  logic [4:0] cur_pos_y, chk_pos_y;
  logic [1:0] cur_rot, chk_rot;
  logic       check_req, lock_req, spawn_pulse, game_over, busy;

  always #5 clk = ~clk;

  piece_move_commit dut (
    .clk(clk), .rst(rst), .mode(mode), .game_tick(game_tick),
    .btn_left_en(btn_left_en), .btn_right_en(btn_right_en),
    .btn_rotate_en(btn_rotate_en), .btn_down_en(btn_down_en),
    .test_pos_x(test_pos_x), .test_pos_y(test_pos_y), .test_rot(test_rot),
    .check_done(check_done), .check_collides(check_collides), .lock_done(lock_done),
    .cur_pos_x(cur_pos_x), .cur_pos_y(cur_pos_y), .cur_rot(cur_rot),
    .chk_pos_x(chk_pos_x), .chk_pos_y(chk_pos_y), .chk_rot(chk_rot),
    .check_req(check_req), .lock_req(lock_req), .spawn_pulse(spawn_pulse),
    .game_over(game_over), .busy(busy)
  );

  // ev = {tick, left, right, rotate, down}; fl = {check_req, lock_req, spawn, over, busy}
  typedef struct {
    logic [2:0] mode;
    logic [4:0] ev;
    logic [3:0] tx; logic [4:0] ty; logic [1:0] tr;
    logic       cd, cc, ld;
    logic [3:0] ex; logic [4:0] ey; logic [1:0] er;
    logic [3:0] kx; logic [4:0] ky; logic [1:0] kr;
    logic [4:0] fl;
  } vec_t;

  localparam int N = 0, TK = 16, L = 8, R = 4, RO = 2, D = 1;

  int   applied = 0;
  int   miscompares = 0;
  vec_t tbl[$];

  function automatic vec_t mk(int md, int ev, int tx, int ty, int tr, int cd, int cc, int ld,
                              int ex, int ey, int er, int kx, int ky, int kr, int fl);
    vec_t t;
    t.mode = 3'(md); t.ev = 5'(ev);
    t.tx = 4'(tx); t.ty = 5'(ty); t.tr = 2'(tr);
    t.cd = 1'(cd); t.cc = 1'(cc); t.ld = 1'(ld);
    t.ex = 4'(ex); t.ey = 5'(ey); t.er = 2'(er);
    t.kx = 4'(kx); t.ky = 5'(ky); t.kr = 2'(kr);
    t.fl = 5'(fl);
    return t;
  endfunction

  task automatic check_out(input string name, input vec_t t);
    logic [26:0] got, expv;
    got  = {cur_pos_x, cur_pos_y, cur_rot, chk_pos_x, chk_pos_y, chk_rot,
            check_req, lock_req, spawn_pulse, game_over, busy};
    expv = {t.ex, t.ey, t.er, t.kx, t.ky, t.kr, t.fl};
    applied++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got cur=%0d,%0d,%0d chk=%0d,%0d,%0d flags=%b ; expected cur=%0d,%0d,%0d chk=%0d,%0d,%0d flags=%b",
               name, cur_pos_x, cur_pos_y, cur_rot, chk_pos_x, chk_pos_y, chk_rot,
               {check_req, lock_req, spawn_pulse, game_over, busy},
               t.ex, t.ey, t.er, t.kx, t.ky, t.kr, t.fl);
    end
  endtask

  task automatic drive(input vec_t t);
    mode = t.mode;
    {game_tick, btn_left_en, btn_right_en, btn_rotate_en, btn_down_en} = t.ev;
    test_pos_x = t.tx; test_pos_y = t.ty; test_rot = t.tr;
    check_done = t.cd; check_collides = t.cc; lock_done = t.ld;
  endtask

  task automatic run(input string name, input vec_t t);
    @(negedge clk);
    drive(t);
    @(posedge clk);
    #1;
    check_out(name, t);
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    drive(mk(0, N, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0));
    #12;
    check_out("reset", mk(0, N, 0,0,0, 0,0,0, 4,0,0, 0,0,0, 5'b00000));
    @(negedge clk);
    rst = 1'b0;

    //            md ev      tx ty tr cd cc ld  cur       chk      flags
    tbl.push_back(mk(0, N,      0, 0, 0, 0, 0, 0,  4, 0, 0,  0, 0, 0, 5'b00000)); // idle
    tbl.push_back(mk(1, N,      0, 0, 0, 0, 0, 0,  4, 0, 0,  0, 0, 0, 5'b00001)); // -> SPAWN
    tbl.push_back(mk(1, N,      0, 0, 0, 0, 0, 0,  4, 0, 0,  4, 0, 0, 5'b10101)); // spawn pulse
    tbl.push_back(mk(1, N,      0, 0, 0, 1, 0, 0,  4, 0, 0,  4, 0, 0, 5'b00000)); // -> PLAY
    tbl.push_back(mk(1, L,      3, 0, 0, 0, 0, 0,  4, 0, 0,  3, 0, 0, 5'b10001)); // left
    tbl.push_back(mk(1, N,      0, 0, 0, 0, 0, 0,  4, 0, 0,  3, 0, 0, 5'b00001)); // waiting
    tbl.push_back(mk(1, N,      0, 0, 0, 1, 0, 0,  3, 0, 0,  3, 0, 0, 5'b00000)); // commit
    tbl.push_back(mk(1, L,      2, 0, 0, 0, 0, 0,  3, 0, 0,  2, 0, 0, 5'b10001)); // left again
    tbl.push_back(mk(1, N,      0, 0, 0, 1, 1, 0,  3, 0, 0,  2, 0, 0, 5'b00000)); // blocked, no lock
    tbl.push_back(mk(1, TK|R,   3, 1, 0, 0, 0, 0,  3, 0, 0,  3, 1, 0, 5'b10001)); // tick beats right
    tbl.push_back(mk(1, N,      0, 0, 0, 1, 1, 0,  3, 0, 0,  3, 1, 0, 5'b01001)); // lock_req
    tbl.push_back(mk(1, N,      0, 0, 0, 0, 0, 0,  3, 0, 0,  3, 1, 0, 5'b00001)); // in LOCK
    tbl.push_back(mk(1, N,      0, 0, 0, 0, 0, 1,  3, 0, 0,  3, 1, 0, 5'b00001)); // lock_done
    tbl.push_back(mk(1, N,      0, 0, 0, 0, 0, 0,  4, 0, 0,  4, 0, 0, 5'b10101)); // respawn
    tbl.push_back(mk(1, N,      0, 0, 0, 1, 0, 0,  4, 0, 0,  4, 0, 0, 5'b00000)); // PLAY
    tbl.push_back(mk(1, L|D,    3, 0, 0, 0, 0, 0,  4, 0, 0,  3, 0, 0, 5'b10001)); // left beats down
    tbl.push_back(mk(1, N,      0, 0, 0, 1, 1, 0,  4, 0, 0,  3, 0, 0, 5'b00000)); // not down: no lock
    tbl.push_back(mk(1, RO,     4, 0, 1, 0, 0, 0,  4, 0, 0,  4, 0, 1, 5'b10001)); // rotate
    tbl.push_back(mk(1, TK,     0, 0, 0, 0, 0, 0,  4, 0, 0,  4, 0, 1, 5'b00001)); // tick deferred
    tbl.push_back(mk(1, TK,     0, 0, 0, 0, 0, 0,  4, 0, 0,  4, 0, 1, 5'b00001)); // second merges
    tbl.push_back(mk(1, N,      0, 0, 0, 1, 0, 0,  4, 0, 1,  4, 0, 1, 5'b00000)); // rot commit
    tbl.push_back(mk(1, N,      0, 0, 0, 0, 0, 0,  4, 0, 1,  4, 1, 1, 5'b10001)); // replayed tick
    tbl.push_back(mk(1, N,      0, 0, 0, 1, 0, 0,  4, 1, 1,  4, 1, 1, 5'b00000)); // drop commit
    tbl.push_back(mk(1, N,      0, 0, 0, 1, 1, 0,  4, 1, 1,  4, 1, 1, 5'b00000)); // one replay only
    tbl.push_back(mk(1, D,      4,31, 1, 0, 0, 0,  4, 1, 1,  4,31, 1, 5'b10001)); // down to row 31
    tbl.push_back(mk(1, TK,     0, 0, 0, 0, 0, 0,  4, 1, 1,  4,31, 1, 5'b00001)); // tick deferred
    tbl.push_back(mk(1, N,      0, 0, 0, 1, 0, 0,  4,31, 1,  4,31, 1, 5'b00000)); // commit row 31
    tbl.push_back(mk(1, N,      0, 0, 0, 0, 0, 0,  4,31, 1,  4, 0, 1, 5'b10001)); // row wraps to 0
    tbl.push_back(mk(1, N,      0, 0, 0, 1, 1, 0,  4,31, 1,  4, 0, 1, 5'b01001)); // lock
    tbl.push_back(mk(0, N,      0, 0, 0, 0, 0, 0,  4,31, 1,  4, 0, 1, 5'b00000)); // abort in LOCK
    tbl.push_back(mk(0, N,      0, 0, 0, 0, 0, 1,  4,31, 1,  4, 0, 1, 5'b00000)); // late lock_done
    tbl.push_back(mk(0, N,      0, 0, 0, 1, 0, 0,  4,31, 1,  4, 0, 1, 5'b00000)); // late check_done
    tbl.push_back(mk(1, N,      0, 0, 0, 0, 0, 0,  4,31, 1,  4, 0, 1, 5'b00001)); // -> SPAWN
    tbl.push_back(mk(1, N,      0, 0, 0, 0, 0, 0,  4, 0, 0,  4, 0, 0, 5'b10101)); // spawn
    tbl.push_back(mk(1, N,      0, 0, 0, 1, 1, 0,  4, 0, 0,  4, 0, 0, 5'b00011)); // game over
    tbl.push_back(mk(1, L,      1, 2, 3, 0, 0, 0,  4, 0, 0,  4, 0, 0, 5'b00011)); // over holds
    tbl.push_back(mk(0, N,      0, 0, 0, 0, 0, 0,  4, 0, 0,  4, 0, 0, 5'b00000)); // mode 0 clears

    foreach (tbl[i]) run($sformatf("vec%0d", i), tbl[i]);

    // Async reset in the middle of a CHECK, with check_req high.
    run("ar_spawn",  mk(1, N, 0,0,0, 0,0,0, 4,0,0, 4,0,0, 5'b00001));
    run("ar_spawn2", mk(1, N, 0,0,0, 0,0,0, 4,0,0, 4,0,0, 5'b10101));
    run("ar_play",   mk(1, N, 0,0,0, 1,0,0, 4,0,0, 4,0,0, 5'b00000));
    run("ar_left",   mk(1, L, 3,0,0, 0,0,0, 4,0,0, 3,0,0, 5'b10001));
    #2;
    rst = 1'b1;
    #1;
    check_out("async_rst", mk(0, N, 0,0,0, 0,0,0, 4,0,0, 0,0,0, 5'b00000));
    @(negedge clk);
    drive(mk(1, N, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0));
    rst = 1'b0;

    // Recovery: a spawn must follow within a bounded number of cycles.
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (spawn_pulse) seen = 1'b1;
    end
    applied++;
    if (!seen) begin
      miscompares++;
      $display("FAIL respawn_wait: spawn_pulse=0 after 8 cycles, required 1");
    end
    check_out("respawn", mk(1, N, 0,0,0, 0,0,0, 4,0,0, 4,0,0, 5'b10101));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
